// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register for the pipelined RISC-V core.
// It registers valid, the WB/MEM/EX control bundle, the source operands, rd, the immediate and the PC.
// It supports hold, load-use bubble insertion and branch flush.
// Two saturating counters record bubble cycles and stall cycles.
module id_ex_pipe_stage #(
   parameter int XLEN        = 32,
   parameter int RA_W        = 5,
   parameter int NUM_SRC     = 2,
   parameter int CTRL_W      = 7,
   parameter int CNT_W       = 16,
   parameter int CLR_PAYLOAD = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    flush_lwstall,
   input  logic                    flush_branch,
   input  logic                    cnt_clr,
   input  logic                    valid_in,
   input  logic [CTRL_W-1:0]       ctrl_in,
   input  logic [NUM_SRC*XLEN-1:0] rs_data_in,
   input  logic [NUM_SRC*RA_W-1:0] rs_addr_in,
   input  logic [RA_W-1:0]         rd_addr_in,
   input  logic [XLEN-1:0]         imm_in,
   input  logic [XLEN-1:0]         pc_in,
   output logic                    valid_out,
   output logic [CTRL_W-1:0]       ctrl_out,
   output logic [NUM_SRC*XLEN-1:0] rs_data_out,
   output logic [NUM_SRC*RA_W-1:0] rs_addr_out,
   output logic [RA_W-1:0]         rd_addr_out,
   output logic [XLEN-1:0]         imm_out,
   output logic [XLEN-1:0]         pc_out,
   output logic [CNT_W-1:0]        bubble_cnt,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam bit               CLR_EN  = (CLR_PAYLOAD != 0);

   logic bubble_sel;   // valid/ctrl are cleared on this edge
   logic load_sel;     // all fields take their inputs on this edge
   logic clr_sel;      // payload is zeroed on this edge
   logic bubble_evt;   // a bubble enters the stage (includes loading an invalid slot)
   logic stall_evt;    // the stage really holds (branch flush beats stall)

   logic              valid_reg;
   logic [CTRL_W-1:0] ctrl_reg;
   logic [RA_W-1:0]   rd_reg;
   logic [XLEN-1:0]   imm_reg;
   logic [XLEN-1:0]   pc_reg;
   logic [CNT_W-1:0]  bubble_cnt_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   // Decode the per-edge action. Priority: flush_branch > stall > flush_lwstall > load.
   always_comb begin
      bubble_sel = flush_branch | (~stall & flush_lwstall);
      load_sel   = ~stall & ~flush_branch & ~flush_lwstall;
      clr_sel    = bubble_sel & CLR_EN;
      bubble_evt = bubble_sel | (load_sel & ~valid_in);
      stall_evt  = stall & ~flush_branch;
   end

   // Valid and control. An invalid slot is loaded with zero control, so it cannot write a register or memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
      end else if (bubble_sel) begin
         valid_reg <= 1'b0;
         ctrl_reg  <= '0;
      end else if (load_sel) begin
         valid_reg <= valid_in;
         ctrl_reg  <= valid_in ? ctrl_in : '0;
      end
   end

   // Scalar payload: rd, the immediate and the PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_reg  <= '0;
         imm_reg <= '0;
         pc_reg  <= '0;
      end else if (load_sel) begin
         rd_reg  <= rd_addr_in;
         imm_reg <= imm_in;
         pc_reg  <= pc_in;
      end else if (clr_sel) begin
         rd_reg  <= '0;
         imm_reg <= '0;
         pc_reg  <= '0;
      end
   end

   // Each source operand has its own value/address register pair.
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [XLEN-1:0] data_reg;
         logic [RA_W-1:0] addr_reg;

         // Operand lane gi follows the same rules as the scalar payload.
         always_ff @(posedge clk) begin
            if (reset) begin
               data_reg <= '0;
               addr_reg <= '0;
            end else if (load_sel) begin
               data_reg <= rs_data_in[gi*XLEN +: XLEN];
               addr_reg <= rs_addr_in[gi*RA_W +: RA_W];
            end else if (clr_sel) begin
               data_reg <= '0;
               addr_reg <= '0;
            end
         end

         assign rs_data_out[gi*XLEN +: XLEN] = data_reg;
         assign rs_addr_out[gi*RA_W +: RA_W] = addr_reg;
      end
   endgenerate

   // Saturating bubble counter. A clear beats a coincident increment.
   always_ff @(posedge clk) begin
      if (reset || cnt_clr)
         bubble_cnt_reg <= '0;
      else if (bubble_evt && bubble_cnt_reg != CNT_MAX)
         bubble_cnt_reg <= bubble_cnt_reg + CNT_ONE;
   end

   // Saturating stall counter. A clear beats a coincident increment.
   always_ff @(posedge clk) begin
      if (reset || cnt_clr)
         stall_cnt_reg <= '0;
      else if (stall_evt && stall_cnt_reg != CNT_MAX)
         stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
   end

   assign valid_out   = valid_reg;
   assign ctrl_out    = ctrl_reg;
   assign rd_addr_out = rd_reg;
   assign imm_out     = imm_reg;
   assign pc_out      = pc_reg;
   assign bubble_cnt  = bubble_cnt_reg;
   assign stall_cnt   = stall_cnt_reg;

endmodule
